product_row_accumulator: RTL and testbench
==========================================

// Module: product_row_accumulator
// PURPOSE
//  Single-clock stage directly downstream of the clk1 output port (out_valid/out_matrix).
//  Consumes the 256-element product stream row-major: 16 rows x 16 columns, 8-bit values.
//  Produces one 12-bit sum per row through a small result queue with a valid/ready interface.
//  Also produces a per-frame grand total and a frame-done pulse.
// PARAMETERS
//  DATA_W   8   width of each incoming product
//  ROW_LEN  16  products per row
//  ROWS     16  rows per frame
//  QDEPTH   4   result-queue entries (power of 2)
//  SUM_W    DATA_W+$clog2(ROW_LEN) = 12 (derived localparam); TOT_W = SUM_W+$clog2(ROWS) = 16
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       async, active-high; no _n suffix because not active-low
//  clr          in   1       sync clear: counters, accumulators, queue, err -> 0
//  in_valid     in   1       product valid
//  in_data      in   DATA_W  product value, row-major order
//  in_ready     out  1       stage can accept in_data this cycle
//  out_valid    out  1       queue head valid
//  out_ready    in   1       consumer takes head
//  out_sum      out  SUM_W   row sum at queue head
//  out_row      out  4       row index of head
//  frame_done   out  1       1-cycle pulse; frame total is valid
//  frame_total  out  TOT_W   sum of all 256 products, held until next frame_done
//  err          out  1       sticky; set when in_valid && !in_ready (sample dropped)
// BEHAVIOUR
//  Reset: every output and register = 0. in_ready = 1 after reset (queue empty).
//  Accept = in_valid && in_ready; acc += in_data; col++.
//  Row end = accept with col==ROW_LEN-1:
//   - push {row, acc+in_data} into queue on that same edge
//   - acc <= 0, col <= 0, row++ (wraps 15->0)
//  in_ready = !(col==ROW_LEN-1 && q_full && !out_ready).
//   - Stalls only on a row-ending sample.
//   - Simultaneous push and pop with a full queue is legal; count stays QDEPTH.
//  out_valid = !q_empty; out_sum/out_row driven from the head register (0 when empty).
//  Pop = out_valid && out_ready. Pointers wrap modulo QDEPTH.
//  Latency: last product of a row accepted at edge N -> out_valid high after edge N (queue empty).
//  FSM:
//   - S_IDLE: no frame in progress. First accept -> S_ACCUM.
//   - S_ACCUM: row-end accept with row==ROWS-1 -> S_DONE.
//   - S_DONE: one cycle. frame_done=1; frame_total latched; tot <= 0. Next state -> S_IDLE.
//   - An accept during S_DONE is legal: it counts toward the next frame, and the FSM goes -> S_ACCUM.
//  Running total tot (TOT_W) adds every accepted sample. Max 225*256=57600 fits 16 bits; no saturation.
//  Err: dropped sample is not accumulated. err stays 1 until rst or clr.
//  clr has priority over accept/pop in the same cycle; FSM -> S_IDLE.
//  rst mid-frame: partial row and frame are discarded; queue is emptied.
// CONFIGURATION
//  ROW_MAX_EN defined:
//   - Adds output out_max [DATA_W-1:0]: the max product in the row at queue head.
//   - out_max is stored in the queue beside the sum; 0 on reset/empty.
//  ROW_MAX_EN undefined: port absent; queue entries hold only {row, sum}.
// STRUCTURE
//  Package product_row_pkg:
//   - DATA_W, ROW_LEN, ROWS, SUM_W, TOT_W defaults
//   - state enum {S_IDLE, S_ACCUM, S_DONE}
//   - typedef row_result_t {row, sum[, max]}
//  Sub-module row_result_queue: sync FIFO of row_result_t with full/empty flags.
//  Top level: accumulate FSM and counters.
// TESTING
//  1. All products 1, out_ready=1 -> 16 results, each sum=16, rows 0..15; frame_total=256; one frame_done.
//  2. All products 225 (15*15) -> each sum=3600; frame_total=57600; no overflow.
//  3. out_ready=0 for a whole frame:
//     - queue fills after row 3; in_ready drops at col 15 of row 4
//     - driving in_valid anyway -> err=1, sample dropped
//     - out_ready=1 -> rows 0..3 pop in order.
//  4. Full queue at row end with out_ready=1 the same cycle -> push+pop together, in_ready stays 1, no err.
//  5. rst asserted at row 7 col 9 -> all outputs 0 next sample.
//     A fresh frame then gives row 0 first and a correct total.
//  6. clr together with a row-end accept -> queue empty, no push, FSM S_IDLE, err=0.
//     With ROW_MAX_EN: row of 0..15 -> out_max=15.

Source files
------------

// File: rtl/product_row_accumulator_pkg.sv
// product_row_pkg: shared widths, FSM state type and queue entry type for
// product_row_accumulator.
// Optional feature macro: ROW_MAX_EN (adds per-row maximum to queue entries).
package product_row_pkg;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ROW_LEN = 16;
  localparam int unsigned ROWS    = 16;
  localparam int unsigned QDEPTH  = 4;
  localparam int unsigned SUM_W   = DATA_W + $clog2(ROW_LEN);
  localparam int unsigned TOT_W   = SUM_W + $clog2(ROWS);
  localparam int unsigned COL_W   = $clog2(ROW_LEN);
  localparam int unsigned ROW_W   = $clog2(ROWS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [SUM_W-1:0]  sum;
`ifdef ROW_MAX_EN
    logic [DATA_W-1:0] max;
`endif
  } row_result_t;
endpackage

// File: rtl/product_row_accumulator_if.sv
// product_row_accumulator_if: product input stream and row-result output
// stream of product_row_accumulator.
//   in_valid/in_data/in_ready     : product stream, row-major
//   out_valid/out_ready           : row-result handshake
//   out_sum/out_row[/out_max]     : row result at queue head
// Optional feature macro: ROW_MAX_EN (adds out_max).
interface product_row_accumulator_if;
  import product_row_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_sum;
  logic [ROW_W-1:0]  out_row;
`ifdef ROW_MAX_EN
  logic [DATA_W-1:0] out_max;
`endif

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_row
`ifdef ROW_MAX_EN
    , input out_max
`endif
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_row
`ifdef ROW_MAX_EN
    , output out_max
`endif
  );
endinterface

// File: rtl/product_row_accumulator_queue.sv
// row_result_queue: synchronous FIFO of row_result_t.
//   clk, rst (async, active-high), clr (sync flush)
//   push/din  : write entry (ignored when full unless popping the same cycle)
//   pop/dout  : head entry, dout is 0 when empty
//   full/empty: occupancy flags
// Optional feature macro: ROW_MAX_EN (entry carries row maximum).
module row_result_queue
  import product_row_pkg::*;
#(
  parameter int unsigned DEPTH = QDEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic        pop,
  input  row_result_t din,
  output row_result_t dout,
  output logic        full,
  output logic        empty
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  row_result_t      mem_q [DEPTH];
  row_result_t      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = empty ? '0 : mem_q[rd_q];

  // Push into a full queue is legal only when the head leaves on the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + 1'b1;
      end
      if (do_pop) rd_d = rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/product_row_accumulator.sv
// product_row_accumulator: sums a 16x16 row-major product stream into one
// result per row (queued, valid/ready) plus a per-frame grand total.
//   clk, rst (async, active-high), clr (sync clear of counters/queue/err)
//   bus (slave)  : in_valid/in_data/in_ready, out_valid/out_ready/out_sum/
//                  out_row[/out_max]
//   frame_done   : 1-cycle pulse, frame_total valid
//   frame_total  : sum of the last complete frame
//   err          : sticky, a sample was offered while in_ready was low
// Optional feature macro: ROW_MAX_EN (per-row maximum on bus.out_max).
module product_row_accumulator
  import product_row_pkg::*;
#(
  parameter int unsigned QDEPTH = product_row_pkg::QDEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  product_row_accumulator_if.slave  bus,
  output logic                      frame_done,
  output logic [TOT_W-1:0]          frame_total,
  output logic                      err
);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LEN - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [TOT_W-1:0]  tot_q, tot_d;
  logic [TOT_W-1:0]  frame_total_q, frame_total_d;
  logic              err_q, err_d;
  logic              q_full, q_empty, in_ready, accept, row_end, push, pop;
  row_result_t       q_din, q_dout;
`ifdef ROW_MAX_EN
  logic [DATA_W-1:0] max_q, max_d, row_max;
  assign row_max = (bus.in_data > max_q) ? bus.in_data : max_q;
`endif

  // Only a row-ending sample needs a queue slot, so only it can stall.
  assign in_ready = !(col_q == COL_LAST && q_full && !bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign row_end  = accept && (col_q == COL_LAST);
  assign push     = row_end && !clr;
  assign pop      = !q_empty && bus.out_ready && !clr;

  always_comb begin
    q_din     = '0;
    q_din.row = row_q;
    q_din.sum = acc_q + SUM_W'(bus.in_data);
`ifdef ROW_MAX_EN
    q_din.max = row_max;
`endif
  end

  row_result_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (q_din),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty)
  );

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    acc_d         = acc_q;
    tot_d         = tot_q;
    frame_total_d = frame_total_q;
    err_d         = err_q;
`ifdef ROW_MAX_EN
    max_d         = max_q;
`endif
    if (clr) begin
      state_d = S_IDLE;
      col_d   = '0;
      row_d   = '0;
      acc_d   = '0;
      tot_d   = '0;
      err_d   = 1'b0;
`ifdef ROW_MAX_EN
      max_d   = '0;
`endif
    end else begin
      if (bus.in_valid && !in_ready) err_d = 1'b1;
      if (accept) begin
        tot_d = tot_q + TOT_W'(bus.in_data);
        if (row_end) begin
          acc_d = '0;
          col_d = '0;
          row_d = row_q + 1'b1;
`ifdef ROW_MAX_EN
          max_d = '0;
`endif
        end else begin
          acc_d = acc_q + SUM_W'(bus.in_data);
          col_d = col_q + 1'b1;
`ifdef ROW_MAX_EN
          max_d = row_max;
`endif
        end
      end
      case (state_q)
        S_IDLE:  if (accept) state_d = S_ACCUM;
        S_ACCUM: ;
        S_DONE:  state_d = accept ? S_ACCUM : S_IDLE;
        default: state_d = S_IDLE;
      endcase
      // Closing the last row latches the total and restarts the running sum,
      // so a sample accepted during S_DONE already belongs to the next frame.
      if (row_end && row_q == ROW_LAST) begin
        state_d       = S_DONE;
        frame_total_d = tot_q + TOT_W'(bus.in_data);
        tot_d         = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      col_q         <= '0;
      row_q         <= '0;
      acc_q         <= '0;
      tot_q         <= '0;
      frame_total_q <= '0;
      err_q         <= 1'b0;
`ifdef ROW_MAX_EN
      max_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      acc_q         <= acc_d;
      tot_q         <= tot_d;
      frame_total_q <= frame_total_d;
      err_q         <= err_d;
`ifdef ROW_MAX_EN
      max_q         <= max_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = !q_empty;
  assign bus.out_sum   = q_dout.sum;
  assign bus.out_row   = q_dout.row;
`ifdef ROW_MAX_EN
  assign bus.out_max   = q_dout.max;
`endif
  assign frame_done    = (state_q == S_DONE);
  assign frame_total   = frame_total_q;
  assign err           = err_q;
endmodule

// File: tb/tb_product_row_accumulator.sv
// Directed bench for product_row_accumulator with hand-computed expectations.
// Optional feature macro: ROW_MAX_EN (adds the row-maximum step).
module tb_product_row_accumulator;
  import product_row_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic             frame_done;
  logic [TOT_W-1:0] frame_total;
  logic             err;

  product_row_accumulator_if bus ();

  product_row_accumulator #(.QDEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .bus         (bus),
    .frame_done  (frame_done),
    .frame_total (frame_total),
    .err         (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int pop_row[$];
  int pop_sum[$];
  int pop_max[$];
  int fd_cnt   = 0;
  int fd_total = 0;

  // Records every pop and every frame_done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && !clr) begin
      if (bus.out_valid && bus.out_ready) begin
        pop_row.push_back(int'(bus.out_row));
        pop_sum.push_back(int'(bus.out_sum));
`ifdef ROW_MAX_EN
        pop_max.push_back(int'(bus.out_max));
`endif
      end
      if (frame_done) begin
        fd_cnt++;
        fd_total = int'(frame_total);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    logic ok;
    int   k;
    ok = 1'b0;
    k  = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!ok && k < 200) begin
      @(negedge clk);
      ok = bus.in_ready;
      tick();
      k++;
    end
    if (!ok) check("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_n(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) send(d);
  endtask

  int b, f;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    clr = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_sum", bus.out_sum, 0);
    check("rst_out_row", bus.out_row, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_total", frame_total, 0);
    check("rst_err", err, 0);

    // 1: all ones, consumer always ready
    bus.out_ready = 1'b1;
    b = pop_row.size();
    f = fd_cnt;
    send_n(8'd1, 256);
    repeat (4) tick();
    check("t1_npop", pop_row.size() - b, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t1_row%0d", i), pop_row[b+i], i);
      check($sformatf("t1_sum%0d", i), pop_sum[b+i], 16);
    end
    check("t1_fd_cnt", fd_cnt - f, 1);
    check("t1_fd_total", fd_total, 256);
    check("t1_frame_total", frame_total, 256);
    check("t1_err", err, 0);

    // 2: all 225, maximum frame total
    b = pop_row.size();
    f = fd_cnt;
    send_n(8'd225, 256);
    repeat (4) tick();
    check("t2_npop", pop_row.size() - b, 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("t2_sum%0d", i), pop_sum[b+i], 3600);
    check("t2_fd_cnt", fd_cnt - f, 1);
    check("t2_frame_total", frame_total, 57600);

    // 3: consumer stalled, queue full, dropped sample
    bus.out_ready = 1'b0;
    b = pop_row.size();
    send_n(8'd1, 64 + 15);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd7;
    @(negedge clk);
    check("t3_in_ready_low", bus.in_ready, 0);
    tick();
    bus.in_valid = 1'b0;
    check("t3_err_set", err, 1);
    check("t3_out_valid", bus.out_valid, 1);
    check("t3_npop_stalled", pop_row.size() - b, 0);
    bus.out_ready = 1'b1;
    repeat (6) tick();
    check("t3_npop", pop_row.size() - b, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_row%0d", i), pop_row[b+i], i);
      check($sformatf("t3_sum%0d", i), pop_sum[b+i], 16);
    end
    send(8'd1);
    repeat (3) tick();
    check("t3_npop_row4", pop_row.size() - b, 5);
    check("t3_row4", pop_row[b+4], 4);
    check("t3_row4_sum_no_drop", pop_sum[b+4], 16);
    check("t3_err_sticky", err, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t3_clr_err", err, 0);
    check("t3_clr_out_valid", bus.out_valid, 0);

    // 4: full queue, row end with simultaneous pop
    bus.out_ready = 1'b0;
    b = pop_row.size();
    for (int r = 0; r < 4; r++) send_n(8'(r + 1), 16);
    send_n(8'd5, 15);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'd5;
    @(negedge clk);
    check("t4_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check("t4_err", err, 0);
    repeat (6) tick();
    check("t4_npop", pop_row.size() - b, 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4_row%0d", i), pop_row[b+i], i);
      check($sformatf("t4_sum%0d", i), pop_sum[b+i], 16 * (i + 1));
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // 5: async reset mid-frame at row 7 col 9
    send_n(8'd2, 7 * 16 + 9);
    rst = 1'b1;
    #2;
    check("t5_out_valid", bus.out_valid, 0);
    check("t5_out_sum", bus.out_sum, 0);
    check("t5_out_row", bus.out_row, 0);
    check("t5_frame_total", frame_total, 0);
    check("t5_frame_done", frame_done, 0);
    check("t5_err", err, 0);
    check("t5_in_ready", bus.in_ready, 1);
    tick();
    rst = 1'b0;
    tick();
    b = pop_row.size();
    f = fd_cnt;
    send_n(8'd2, 256);
    repeat (4) tick();
    check("t5_npop", pop_row.size() - b, 16);
    check("t5_first_row", pop_row[b], 0);
    check("t5_first_sum", pop_sum[b], 32);
    check("t5_last_row", pop_row[b+15], 15);
    check("t5_fd_cnt", fd_cnt - f, 1);
    check("t5_fd_total", fd_total, 512);

    // 6: clr together with a row-end accept
    bus.out_ready = 1'b0;
    send_n(8'd3, 15);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd3;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bus.in_valid = 1'b0;
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_err", err, 0);
    check("t6_state_idle", dut.state_q, S_IDLE);
    bus.out_ready = 1'b1;
    b = pop_row.size();
    send_n(8'd4, 16);
    repeat (3) tick();
    check("t6_npop", pop_row.size() - b, 1);
    check("t6_row", pop_row[b], 0);
    check("t6_sum", pop_sum[b], 64);

`ifdef ROW_MAX_EN
    // Row of 0..15: maximum 15, sum 120
    b = pop_row.size();
    for (int i = 0; i < 16; i++) send(8'(i));
    repeat (3) tick();
    check("mx_npop", pop_row.size() - b, 1);
    check("mx_sum", pop_sum[b], 120);
    check("mx_max", pop_max[b], 15);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
